// File: rtl/mdu_seq_ctrl_if.sv
// Request/response and shared-adder signals of the iterative multiply/divide sequencer.
// The slave side is the sequencer; the master side is the pipeline plus the shared adder.
interface mdu_seq_ctrl_if #(
   parameter int WIDTH = 32
);
   logic             i_start;
   logic [1:0]       i_op;
   logic [WIDTH-1:0] i_rs1;
   logic [WIDTH-1:0] i_rs2;
   logic             o_ready;
   logic             o_valid;
   logic [WIDTH-1:0] o_result;
   logic [WIDTH-1:0] o_add_a;
   logic [WIDTH-1:0] o_add_b;
   logic             o_add_cin;
   logic [WIDTH-1:0] i_add_result;
   logic             i_add_cout;

   modport slave (
      input  i_start, i_op, i_rs1, i_rs2, i_add_result, i_add_cout,
      output o_ready, o_valid, o_result, o_add_a, o_add_b, o_add_cin
   );

   modport master (
      output i_start, i_op, i_rs1, i_rs2, i_add_result, i_add_cout,
      input  o_ready, o_valid, o_result, o_add_a, o_add_b, o_add_cin
   );
endinterface

// File: rtl/mdu_seq_ctrl.sv
// Unsigned MUL/MULHU/DIVU/REMU sequencer: 32 iterations on the shared ALU adder,
// shift-add for multiply, restoring subtract for divide.
module mdu_seq_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic                i_clk,
   input  logic                i_reset,
   mdu_seq_ctrl_if.slave       bus
);
   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [1:0]       op_reg;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] b_reg;
   logic [CNT_W-1:0] cnt;
   logic             valid_reg;
   logic [WIDTH-1:0] result_reg;

   logic [WIDTH-1:0] add_a;
   logic [WIDTH-1:0] add_b;
   logic             add_cin;
   logic [WIDTH-1:0] p;
   logic             take;
   logic [WIDTH-1:0] acc_nxt;
   logic [WIDTH-1:0] q_nxt;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      add_a   = '0;
      add_b   = '0;
      add_cin = 1'b0;
      take    = 1'b0;
      p       = {acc[WIDTH-2:0], q[WIDTH-1]};
      acc_nxt = acc;
      q_nxt   = q;
      if (state == CALC) begin
         add_b = b_reg;
         if (!op_reg[1]) begin
            add_a = acc;
            if (q[0])
               {acc_nxt, q_nxt} = {bus.i_add_cout, bus.i_add_result, q[WIDTH-1:1]};
            else
               {acc_nxt, q_nxt} = {1'b0, acc, q[WIDTH-1:1]};
         end else begin
            // ACC's top bit set means P overflowed WIDTH bits, so the subtract always fits.
            add_a   = p;
            add_cin = 1'b1;
            take    = acc[WIDTH-1] | bus.i_add_cout;
            acc_nxt = take ? bus.i_add_result : p;
            q_nxt   = {q[WIDTH-2:0], take};
         end
      end
   end

   assign bus.o_add_a   = add_a;
   assign bus.o_add_b   = add_b;
   assign bus.o_add_cin = add_cin;
   assign bus.o_ready   = (state == IDLE);
   assign bus.o_valid   = valid_reg;
   assign bus.o_result  = result_reg;

   // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         // NOTE: the datapath registers are plain flops, not memory, so they are cleared with the FSM.
         state      <= IDLE;
         op_reg     <= '0;
         acc        <= '0;
         q          <= '0;
         b_reg      <= '0;
         cnt        <= '0;
         valid_reg  <= 1'b0;
         result_reg <= '0;
      end else begin
         valid_reg <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.i_start) begin
                  op_reg <= bus.i_op;
                  b_reg  <= bus.i_rs2;
                  q      <= bus.i_rs1;
                  acc    <= '0;
                  cnt    <= '0;
                  state  <= CALC;
               end
            end
            CALC: begin
               acc <= acc_nxt;
               q   <= q_nxt;
               cnt <= cnt + 1'b1;
               if (cnt == CNT_LAST) begin
                  // op[0] picks the high half (MULHU/REMU = ACC) versus the low half (MUL/DIVU = Q).
                  result_reg <= op_reg[0] ? acc_nxt : q_nxt;
                  valid_reg  <= 1'b1;
                  state      <= DONE;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/mdu_seq_ctrl.md
# mdu_seq_ctrl

Iterative sequencer for unsigned RV32M multiply/divide (MUL, MULHU, DIVU, REMU) that needs no private arithmetic. It time-multiplexes the shared 32-bit `alu_add_sub` unit for 32 cycles: shift-add for multiply, restoring subtract for divide. It sits beside the single-cycle ALU, receives operands from the register-file read ports, and returns one result with a valid pulse.

## Interface
- `WIDTH`, default 32: operand and result width. The iteration counter is $clog2(WIDTH) bits wide.
- `i_clk`  in  1  clock; all state updates on its rising edge.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_start`  in  1  request; accepted only on an edge where `o_ready`=1.
- `i_op`  in  2  operation: 00 MUL (low word), 01 MULHU (high word), 10 DIVU, 11 REMU.
- `i_rs1`  in  WIDTH  multiplicand or dividend.
- `i_rs2`  in  WIDTH  multiplier or divisor.
- `o_ready`  out  1  high only in IDLE.
- `o_valid`  out  1  one-cycle pulse; `o_result` is valid during it.
- `o_result`  out  WIDTH  registered result; holds its value until the next completion.
- `o_add_a`  out  WIDTH  adder operand A.
- `o_add_b`  out  WIDTH  adder operand B.
- `o_add_cin`  out  1  adder carry-in; 1 selects subtract.
- `i_add_result`  in  WIDTH  adder sum, `a + (cin ? ~b : b) + cin`.
- `i_add_cout`  in  1  adder carry-out.

## Operation
- **States:** IDLE, CALC, DONE.
- **IDLE to CALC:** on `i_start`=1.
  - Latch `i_op`.
  - Latch `B <= i_rs2`, `Q <= i_rs1`.
  - Clear `ACC` and `cnt`.
- **CALC:** one iteration per cycle. `cnt` increments each cycle. On the edge where `cnt`=WIDTH-1, the final iteration completes and the state moves to DONE.
- **DONE:**
  - `o_valid`=1 for this one cycle.
  - Move to IDLE on the next edge.
  - `o_result` is loaded on the CALC-to-DONE edge.
- **Multiply iteration (op 0x):**
  - Adder is driven with `a=ACC`, `b=B`, `cin=0`.
  - If `Q[0]`=1: `{ACC,Q} <= {i_add_cout, i_add_result, Q} >> 1`.
  - If `Q[0]`=0: `{ACC,Q} <= {1'b0, ACC, Q} >> 1`.
  - Final result: MUL gives `Q`, MULHU gives `ACC`.
- **Divide iteration (op 1x):**
  - Partial remainder `P = {ACC[WIDTH-2:0], Q[WIDTH-1]}`.
  - Adder is driven with `a=P`, `b=B`, `cin=1`.
  - Subtract succeeds when `take = ACC[WIDTH-1] | i_add_cout`.
  - `ACC <= take ? i_add_result : P`.
  - `Q <= {Q[WIDTH-2:0], take}`.
  - Final result: DIVU gives `Q`, REMU gives `ACC`.
- **Divide by zero:** no special path. The loop yields DIVU = all ones and REMU = dividend, which matches RISC-V semantics. The bench checks this.
- **Adder drive outside CALC:** `o_add_a`, `o_add_b`, `o_add_cin` are all 0.
- **Busy or DONE:** `i_start` is ignored. Operand inputs are don't-care after the accepting edge.
- **Reset:**
  - Resets from any state, including mid-CALC, with no output pulse.
  - State goes to IDLE.
  - `o_valid`=0, `o_result`=0, `ACC`/`Q`/`B`/`cnt`=0.
  - `o_ready`=1 in the cycle after the reset edge.
  - Reset wins over a simultaneous `i_start`.

## Timing
- **Latency:** `i_start` accepted at edge N gives CALC on edges N+1..N+32 and `o_valid` high between edges N+32 and N+33.
  - Latency is exactly 32 cycles from accept to `o_valid`, independent of operands.
- **Throughput:** with `i_start` held high, the next accept is at edge N+34, giving one op per 34 cycles.
- **Combinational signals:**
  - `o_ready` and `o_add_*` are combinational from registered state only.
  - `i_add_*` are consumed in the same cycle.
  - The path register → `o_add_*` → `alu_add_sub` → `i_add_*` → register is one clock period. No combinational path from `i_start` or operands to any output.
- **Output registering:** `o_valid` and `o_result` are registered.

## Test plan
- **Small multiply:** MUL 7×6, then MULHU 7×6.
  - Required: `o_result` 42 with `o_valid` exactly 32 cycles after accept, then 0.
  - Check `o_add_cin`=0 throughout CALC.
- **Maximum multiply:** MUL and MULHU of 0xFFFFFFFF×0xFFFFFFFF.
  - Required: 0x00000001 and 0xFFFFFFFE.
- **Divide:** DIVU and REMU of 100/7.
  - Required: 14 and 2.
  - Also 0x80000000/0x00000003 must give quotient 0x2AAAAAAA and remainder 0x00000002.
- **Divide by zero:** DIVU and REMU of 0x00001234/0.
  - Required: 0xFFFFFFFF and 0x00001234.
- **Reset and ignored start:**
  - Pulse `i_start` with different operands during CALC: the original result is unaffected.
  - Assert `i_reset` at iteration 10 of a divide: no `o_valid`, `o_result`=0, `o_ready`=1 the next cycle.
  - A following MUL 3×5 then returns 15.
- **Back-to-back:** hold `i_start`=1 for three ops.
  - Required: accepts every 34 cycles, `o_valid` never high two cycles in a row, and each result matches its own operands.
